// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - main control FSM for the multicycle RV32I core
// Optional retired-instruction counter (instret) enabled by defining MC_FSM_INSTRET_EN.
module multicycle_main_fsm #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
`ifdef MC_FSM_INSTRET_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       fault,
  output logic       fault_cause,
  output logic [3:0] state_o
`ifdef MC_FSM_INSTRET_EN
  ,
  output logic [CNT_W-1:0] instret
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              fault_cause_q, fault_cause_d;

  logic req_raw, wr_raw, irw_raw, regw_raw, pc_update, branch, waiting;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      fault_cause_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    fault_cause_d = fault_cause_q;
    waiting       = req_raw & ~mem_ready;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d       = S_FAULT;
            fault_cause_d = 1'b0;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW)      state_d = S_MEMWRITE;
        else if (opcode == OP_LW) state_d = S_MEMREAD;
        else begin
          state_d       = S_FAULT;
          fault_cause_d = 1'b0;
        end
      end
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default: begin
        state_d       = S_FAULT;
        fault_cause_d = 1'b0;
      end
    endcase
    // the TIMEOUT-th consecutive stalled cycle traps; a ready in that cycle never reaches here
    if (waiting) begin
      if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
        state_d       = S_FAULT;
        fault_cause_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  always_comb begin
    req_raw    = 1'b0;
    wr_raw     = 1'b0;
    irw_raw    = 1'b0;
    regw_raw   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (state_q)
      S_FETCH: begin
        req_raw    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw_raw    = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        req_raw = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        regw_raw   = 1'b1;
      end
      S_MEMWRITE: begin
        req_raw = 1'b1;
        wr_raw  = 1'b1;
        adr_src = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: regw_raw = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // reset is asynchronous, so strobes are masked combinationally while it is high
  assign mem_req     = req_raw & ~reset;
  assign mem_write   = wr_raw & ~reset;
  assign ir_write    = irw_raw & ~reset;
  assign reg_write   = regw_raw & ~reset;
  assign pc_write    = (pc_update | (branch & zero)) & ~reset;
  assign fault       = (state_q == S_FAULT);
  assign fault_cause = fault_cause_q;
  assign state_o     = state_q;

`ifdef MC_FSM_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  always_comb begin
    retire    = (state_q == S_MEMWB) | (state_q == S_ALUWB) | (state_q == S_BEQ) |
                ((state_q == S_MEMWRITE) & mem_ready);
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - randomized self-checking bench for multicycle_main_fsm
module tb_multicycle_main_fsm;

  localparam int TIMEOUT = 15;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = OP_R;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;
  logic       fault, fault_cause;
  logic [3:0] state_o;
`ifdef MC_FSM_INSTRET_EN
  logic [31:0] instret;
`endif

  multicycle_main_fsm #(.WAIT_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .imm_src(imm_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .fault(fault),
    .fault_cause(fault_cause), .state_o(state_o)
`ifdef MC_FSM_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] imm_src, a, b, alu_op, result_src;
    logic       fault, fault_cause;
    logic [3:0] st;
  } outs_t;

  outs_t       act, exp_o;
  outs_t       trace[$];
  int          checks = 0;
  int          failures = 0;
  logic        exp_valid = 1'b0;
  logic        m_cause = 1'b0;
  logic [31:0] m_instret = '0;
  logic [31:0] exp_instret = '0;

  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                imm_src, alu_src_a, alu_src_b, alu_op, result_src, fault, fault_cause, state_o};

  // Reference table: what each architectural step must drive
  function automatic outs_t expect_outs(input int st, input logic rdy, input logic z,
                                        input logic [6:0] op, input logic cause);
    outs_t o;
    o = '0;
    o.st = 4'(st);
    o.imm_src = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
    case (st)
      0:  begin o.mem_req = 1; o.b = 2; o.result_src = 2; o.ir_write = rdy; o.pc_write = rdy; end
      1:  begin o.a = 1; o.b = 1; end
      2:  begin o.a = 2; o.b = 1; end
      3:  begin o.mem_req = 1; o.adr_src = 1; end
      4:  begin o.result_src = 1; o.reg_write = 1; end
      5:  begin o.mem_req = 1; o.mem_write = 1; o.adr_src = 1; end
      6:  begin o.a = 2; o.alu_op = 2; end
      7:  begin o.a = 2; o.b = 1; o.alu_op = 2; end
      8:  o.reg_write = 1;
      9:  begin o.a = 2; o.alu_op = 1; o.pc_write = z; end
      10: begin o.a = 1; o.b = 2; o.pc_write = 1; end
      11: begin o.fault = 1; o.fault_cause = cause; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_o) begin
        failures++;
        $display("FAIL outputs step=%0d actual=%h required=%h", exp_o.st, act, exp_o);
      end
`ifdef MC_FSM_INSTRET_EN
      checks++;
      if (instret !== exp_instret) begin
        failures++;
        $display("FAIL instret actual=%0d required=%0d", instret, exp_instret);
      end
`endif
    end
  end

  task automatic lit(input string name, input int a, input int r);
    checks++;
    if (a != r) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, a, r);
    end
  endtask

  task automatic step(input int st, input logic rdy, input logic z, input logic [6:0] op);
    opcode = op; zero = z; mem_ready = rdy;
    exp_o = expect_outs(st, rdy, z, op, m_cause);
    exp_instret = m_instret;
    exp_valid = 1'b1;
    #2 trace.push_back(act);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    outs_t o;
    reset = 1'b1; zero = 1'($urandom); mem_ready = 1'($urandom);
    m_cause = 1'b0; m_instret = '0;
    o = expect_outs(0, mem_ready, zero, opcode, 1'b0);
    o.mem_req = 0; o.mem_write = 0; o.ir_write = 0; o.pc_write = 0; o.reg_write = 0;
    exp_o = o; exp_instret = '0; exp_valid = 1'b1;
    #2 trace.push_back(act);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic fault_hold(input logic [6:0] op);
    for (int k = 0; k < 3; k++) step(11, 1'($urandom), 1'($urandom), op);
    do_reset();
  endtask

  function automatic logic pick_z(input int zmode);
    return (zmode == 2) ? 1'($urandom) : (zmode == 1);
  endfunction

  function automatic int rand_stall();
    if ($urandom_range(0, 24) == 0) return TIMEOUT;
    return ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
  endfunction

  // One instruction: an ordered list of steps; request steps may stall on mem_ready.
  task automatic run_instr(input logic [6:0] op, input bit rnd, input int stall_ph,
                           input int stall_n, input int zmode, input int abort_ph);
    int seq[$];
    case (op)
      OP_LW:   seq = '{0, 1, 2, 3, 4};
      OP_SW:   seq = '{0, 1, 2, 5};
      OP_R:    seq = '{0, 1, 6, 8};
      OP_I:    seq = '{0, 1, 7, 8};
      OP_BEQ:  seq = '{0, 1, 9};
      OP_JAL:  seq = '{0, 1, 10, 8};
      default: seq = '{0, 1, 11};
    endcase
    trace.delete();
    for (int i = 0; i < seq.size(); i++) begin
      int ph;
      int n;
      ph = seq[i];
      if (i == abort_ph) begin
        do_reset();
        return;
      end
      if (ph == 11) begin
        m_cause = 1'b0;
        fault_hold(op);
        return;
      end
      if (ph == 0 || ph == 3 || ph == 5) begin
        n = (i == stall_ph) ? stall_n : (rnd ? rand_stall() : 0);
        for (int w = 0; w < n && w < TIMEOUT; w++) step(ph, 1'b0, pick_z(zmode), op);
        if (n >= TIMEOUT) begin
          m_cause = 1'b1;
          fault_hold(op);
          return;
        end
        step(ph, 1'b1, pick_z(zmode), op);
      end else begin
        step(ph, 1'($urandom), pick_z(zmode), op);
      end
    end
    m_instret = m_instret + 32'd1;
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] op;
    int         abort_ph;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

    @(posedge clk); #1;
    trace.delete();
    do_reset();
    lit("reset_state", int'(trace[0].st), 0);
    lit("reset_mem_req", int'(trace[0].mem_req), 0);

    run_instr(OP_R, 0, -1, 0, 2, -1);
    lit("add_len", trace.size(), 4);
    lit("add_s2", int'(trace[2].st), 6);
    lit("add_s3", int'(trace[3].st), 8);
    lit("add_regwrite_c4", int'(trace[3].reg_write), 1);

    run_instr(OP_LW, 0, 3, 3, 2, -1);
    lit("lw_stall_len", trace.size(), 8);
    lit("lw_stall_state", int'(trace[5].st), 3);
    lit("lw_stall_req_adr", int'(trace[4].mem_req & trace[4].adr_src), 1);
    lit("lw_memwb", int'(trace[7].st), 4);

    run_instr(OP_LW, 0, -1, 0, 2, -1);
    lit("lw_latency", trace.size(), 5);
    run_instr(OP_SW, 0, -1, 0, 2, -1);
    lit("sw_latency", trace.size(), 4);
    run_instr(OP_I, 0, -1, 0, 2, -1);
    lit("addi_latency", trace.size(), 4);
    run_instr(OP_JAL, 0, -1, 0, 2, -1);
    lit("jal_latency", trace.size(), 4);
    run_instr(OP_BEQ, 0, -1, 0, 1, -1);
    lit("beq_latency", trace.size(), 3);
    lit("beq_taken_pcw", int'(trace[2].pc_write), 1);
    run_instr(OP_BEQ, 0, -1, 0, 0, -1);
    lit("beq_not_taken_pcw", int'(trace[2].pc_write), 0);

    run_instr(OP_BAD, 0, -1, 0, 2, -1);
    lit("illegal_state", int'(trace[2].st), 11);
    lit("illegal_cause", int'(trace[3].fault_cause), 0);
    lit("illegal_strobes", int'(trace[4].mem_req | trace[4].reg_write | trace[4].pc_write), 0);

    run_instr(OP_R, 0, 0, 15, 2, -1);
    lit("timeout_state", int'(trace[15].st), 11);
    lit("timeout_cause", int'(trace[15].fault_cause), 1);
    lit("timeout_last_fetch", int'(trace[14].st), 0);

    run_instr(OP_R, 0, 0, 14, 2, -1);
    lit("ready15_irw", int'(trace[14].ir_write), 1);
    lit("ready15_decode", int'(trace[15].st), 1);
    lit("ready15_nofault", int'(trace[15].fault), 0);

    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 13) < 12) begin
        op = ops[$urandom_range(0, 5)];
      end else begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end
      abort_ph = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 4) : -1;
      run_instr(op, 1, -1, 0, 2, abort_ph);
    end

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
